// File: rtl/rvv_backend_pkg.sv
// Shared types for the vector backend retire path: ROB->retire uop record,
// VRF/XRF write records, element-class and write-target encodings, FSM states.
package rvv_backend_pkg;

    localparam int NUM_RT_UOP = 4;
    localparam int VLENB      = 16;
    localparam int VREG_AW    = 5;
    localparam int XLEN       = 32;

    typedef enum logic [1:0] {
        BODY_ACTIVE   = 2'd0,
        BODY_INACTIVE = 2'd1,
        TAIL          = 2'd2,
        NOT_CHANGE    = 2'd3
    } vd_type_e;

    typedef enum logic {
        VRF = 1'b0,
        XRF = 1'b1
    } w_type_e;

    typedef logic [0:0] RT_FSM_t;
    localparam RT_FSM_t IDLE      = 1'b0;
    localparam RT_FSM_t TRAP_WAIT = 1'b1;

    typedef struct packed {
        logic                       w_valid;
        logic [VREG_AW-1:0]         w_index;
        logic [8*VLENB-1:0]         w_data;
        w_type_e                    w_type;
        vd_type_e [VLENB-1:0]       vd_type;
        logic                       trap_flag;
        logic [XLEN-1:0]            vector_csr;
        logic [VLENB-1:0]           vxsaturate;
    } ROB2RT_t;

    typedef struct packed {
        logic [VREG_AW-1:0]         rt_index;
        logic [8*VLENB-1:0]         rt_data;
        logic [VLENB-1:0]           rt_strobe;
    } RT2VRF_t;

    typedef struct packed {
        logic [XLEN-1:0]            rt_data;
        logic [4:0]                 rt_index;
    } RT2XRF_t;

    // Byte write-enables: only body-active elements are updated in the VRF.
    function automatic logic [VLENB-1:0] active_strobe(input vd_type_e [VLENB-1:0] vd);
        logic [VLENB-1:0] s;
        s = '0;
        for (int b = 0; b < VLENB; b++) begin
            s[b] = (vd[b] == BODY_ACTIVE);
        end
        return s;
    endfunction

endpackage

// File: rtl/rvv_backend_retire_waw.sv
// Write-after-write filter across the retire lanes: a byte written by an older
// lane is dropped when a younger lane retiring in the same cycle writes that
// same byte of the same vector register.
module rvv_backend_retire_waw
    import rvv_backend_pkg::*;
(
    input  logic [NUM_RT_UOP-1:0]                 wen,
    input  logic [NUM_RT_UOP-1:0][VREG_AW-1:0]    index,
    input  logic [NUM_RT_UOP-1:0][VLENB-1:0]      strobe,
    output logic [NUM_RT_UOP-1:0][VLENB-1:0]      eff_strobe,
    output logic [NUM_RT_UOP-1:0]                 eff_valid
);

    logic [VLENB-1:0] younger;

    // Mask each lane's strobe by the union of younger same-register strobes.
    always_comb begin
        eff_strobe = '0;
        eff_valid  = '0;
        younger    = '0;
        for (int i = 0; i < NUM_RT_UOP; i++) begin
            younger = '0;
            for (int j = i + 1; j < NUM_RT_UOP; j++) begin
                if (wen[j] && (index[j] == index[i])) begin
                    younger = younger | strobe[j];
                end
            end
            eff_strobe[i] = wen[i] ? (strobe[i] & ~younger) : '0;
            eff_valid[i]  = |eff_strobe[i];
        end
    end

endmodule

// File: rtl/rvv_backend_retire.sv
// Retire unit: accepts in-order uops from the ROB, registers VRF writes, holds
// one scalar result for the scalar core, pulses vxsat, and parks in TRAP_WAIT
// after a trapping uop until the RVS acknowledges.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  IDLE      | retiring normally, ready chain enabled
//  TRAP_WAIT | trapping uop retired, trap_done_valid high, all ready low
module rvv_backend_retire
    import rvv_backend_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_RT_UOP-1:0]            rd_valid_rob2rt,
    input  ROB2RT_t [NUM_RT_UOP-1:0]         rd_rob2rt,
    output logic [NUM_RT_UOP-1:0]            rd_ready_rt2rob,
    output logic [NUM_RT_UOP-1:0]            wr_valid_rt2vrf,
    output RT2VRF_t [NUM_RT_UOP-1:0]         wr_rt2vrf,
    output logic                             wr_valid_rt2xrf,
    output RT2XRF_t                          wr_rt2xrf,
    input  logic                             wr_ready_xrf2rt,
    output logic                             vxsat_valid,
    output logic                             trap_done_valid,
    input  logic                             trap_done_ready
);

    RT_FSM_t                            state;
    logic                               run_q;
    logic [NUM_RT_UOP-1:0]              is_trap, is_xrf, is_vrf, stop, ready, accept, vrf_wen;
    logic [NUM_RT_UOP-1:0][VREG_AW-1:0] vrf_index;
    logic [NUM_RT_UOP-1:0][VLENB-1:0]   base_strobe, eff_strobe;
    logic [NUM_RT_UOP-1:0]              eff_valid;
    logic                               xrf_free, xrf_load, trap_accept, vxsat_nxt, later_xrf;
    RT2XRF_t                            xrf_load_data;
    logic                               unused_csr;

    // Per-lane decode; a trapping lane never counts as a VRF or XRF writer.
    always_comb begin
        is_trap     = '0;
        is_xrf      = '0;
        is_vrf      = '0;
        vrf_index   = '0;
        base_strobe = '0;
        unused_csr  = 1'b0;
        for (int i = 0; i < NUM_RT_UOP; i++) begin
            is_trap[i]     = rd_rob2rt[i].trap_flag;
            is_xrf[i]      = rd_rob2rt[i].w_valid & (rd_rob2rt[i].w_type == XRF) & ~rd_rob2rt[i].trap_flag;
            is_vrf[i]      = rd_rob2rt[i].w_valid & (rd_rob2rt[i].w_type == VRF) & ~rd_rob2rt[i].trap_flag;
            vrf_index[i]   = rd_rob2rt[i].w_index;
            base_strobe[i] = active_strobe(rd_rob2rt[i].vd_type);
            unused_csr     = unused_csr ^ (^rd_rob2rt[i].vector_csr);
        end
    end

    // Ready chain: contiguous prefix, cut after a trap or after an XRF lane
    // that has another XRF lane behind it; XRF lanes also need a free slot.
    always_comb begin
        stop      = '0;
        ready     = '0;
        later_xrf = 1'b0;
        xrf_free  = ~wr_valid_rt2xrf | wr_ready_xrf2rt;
        for (int k = NUM_RT_UOP - 1; k >= 0; k--) begin
            stop[k]   = is_trap[k] | (is_xrf[k] & later_xrf);
            later_xrf = later_xrf | is_xrf[k];
        end
        ready[0] = run_q & (state == IDLE) & (~is_xrf[0] | xrf_free);
        for (int i = 1; i < NUM_RT_UOP; i++) begin
            ready[i] = ready[i-1] & ~stop[i-1] & (~is_xrf[i] | xrf_free);
        end
    end

    assign rd_ready_rt2rob = ready;

    // In-order accept and the per-cycle retire side effects.
    always_comb begin
        accept        = '0;
        xrf_load      = 1'b0;
        xrf_load_data = '0;
        trap_accept   = 1'b0;
        vxsat_nxt     = 1'b0;
        accept[0]     = rd_valid_rob2rt[0] & ready[0];
        for (int i = 1; i < NUM_RT_UOP; i++) begin
            accept[i] = accept[i-1] & rd_valid_rob2rt[i] & ready[i];
        end
        for (int i = 0; i < NUM_RT_UOP; i++) begin
            if (accept[i] && is_xrf[i]) begin
                xrf_load      = 1'b1;
                xrf_load_data = {rd_rob2rt[i].w_data[XLEN-1:0], rd_rob2rt[i].w_index};
            end
            trap_accept = trap_accept | (accept[i] & is_trap[i]);
            vxsat_nxt   = vxsat_nxt | (accept[i] & (|rd_rob2rt[i].vxsaturate));
        end
    end

    assign vrf_wen = accept & is_vrf;

    rvv_backend_retire_waw u_waw (
        .wen        (vrf_wen),
        .index      (vrf_index),
        .strobe     (base_strobe),
        .eff_strobe (eff_strobe),
        .eff_valid  (eff_valid)
    );

    // Trap FSM; run_q keeps ready low until the first clock after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (state == IDLE) begin
                if (trap_accept) state <= TRAP_WAIT;
            end else if (trap_done_ready) begin
                state <= IDLE;
            end
        end
    end

    assign trap_done_valid = (state == TRAP_WAIT);

    // Registered VRF write stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_valid_rt2vrf <= '0;
            wr_rt2vrf       <= '0;
        end else begin
            wr_valid_rt2vrf <= eff_valid;
            for (int i = 0; i < NUM_RT_UOP; i++) begin
                if (eff_valid[i]) begin
                    wr_rt2vrf[i] <= {rd_rob2rt[i].w_index, rd_rob2rt[i].w_data, eff_strobe[i]};
                end
            end
        end
    end

    // One-entry scalar result buffer; a load wins over a same-cycle drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_valid_rt2xrf <= 1'b0;
            wr_rt2xrf       <= '0;
        end else if (xrf_load) begin
            wr_valid_rt2xrf <= 1'b1;
            wr_rt2xrf       <= xrf_load_data;
        end else if (wr_ready_xrf2rt) begin
            wr_valid_rt2xrf <= 1'b0;
        end
    end

    // vxsat pulse one cycle after any accepted saturating uop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vxsat_valid <= 1'b0;
        else        vxsat_valid <= vxsat_nxt;
    end

endmodule

// File: tb/tb_rvv_backend_retire.sv
// Bench for rvv_backend_retire: directed retire scenarios with literal
// expectations plus a lane-walking reference model compared every cycle.
module tb_rvv_backend_retire;
    import rvv_backend_pkg::*;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b1;
    logic [NUM_RT_UOP-1:0]       rd_valid_rob2rt;
    ROB2RT_t [NUM_RT_UOP-1:0]    rd_rob2rt;
    logic [NUM_RT_UOP-1:0]       rd_ready_rt2rob;
    logic [NUM_RT_UOP-1:0]       wr_valid_rt2vrf;
    RT2VRF_t [NUM_RT_UOP-1:0]    wr_rt2vrf;
    logic                        wr_valid_rt2xrf;
    RT2XRF_t                     wr_rt2xrf;
    logic                        wr_ready_xrf2rt;
    logic                        vxsat_valid;
    logic                        trap_done_valid;
    logic                        trap_done_ready;

    int checks = 0;
    int failures = 0;

    rvv_backend_retire dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rd_valid_rob2rt (rd_valid_rob2rt),
        .rd_rob2rt       (rd_rob2rt),
        .rd_ready_rt2rob (rd_ready_rt2rob),
        .wr_valid_rt2vrf (wr_valid_rt2vrf),
        .wr_rt2vrf       (wr_rt2vrf),
        .wr_valid_rt2xrf (wr_valid_rt2xrf),
        .wr_rt2xrf       (wr_rt2xrf),
        .wr_ready_xrf2rt (wr_ready_xrf2rt),
        .vxsat_valid     (vxsat_valid),
        .trap_done_valid (trap_done_valid),
        .trap_done_ready (trap_done_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit                 m_run = 0;
    bit                 m_trap = 0;
    bit                 m_xv = 0;
    RT2XRF_t            m_xdata = '0;
    logic [3:0]         m_vv = '0;
    RT2VRF_t [3:0]      m_vrf = '0;
    bit                 m_vxsat = 0;
    int                 owner [32][VLENB];

    function automatic bit lane_xrf(input int i);
        return rd_rob2rt[i].w_valid && rd_rob2rt[i].w_type == XRF && !rd_rob2rt[i].trap_flag;
    endfunction

    function automatic bit lane_vrf(input int i);
        return rd_rob2rt[i].w_valid && rd_rob2rt[i].w_type == VRF && !rd_rob2rt[i].trap_flag;
    endfunction

    // Walk lanes oldest-first until something prevents further retirement.
    function automatic logic [3:0] model_ready();
        logic [3:0] r;
        bit slot_free;
        bit more_xrf;
        r = '0;
        slot_free = !m_xv || wr_ready_xrf2rt;
        if (!m_run || m_trap) return r;
        for (int i = 0; i < 4; i++) begin
            if (lane_xrf(i) && !slot_free) break;
            r[i] = 1'b1;
            if (rd_rob2rt[i].trap_flag) break;
            if (lane_xrf(i)) begin
                more_xrf = 0;
                for (int j = i + 1; j < 4; j++) if (lane_xrf(j)) more_xrf = 1;
                if (more_xrf) break;
            end
        end
        return r;
    endfunction

    // Advance the model: last accepted writer owns each byte of a register.
    always @(posedge clk or negedge rst_n) begin
        logic [3:0] rdy;
        int nacc;
        if (!rst_n) begin
            m_run = 0; m_trap = 0; m_xv = 0; m_xdata = '0;
            m_vv = '0; m_vrf = '0; m_vxsat = 0;
        end else begin
            rdy = model_ready();
            nacc = 0;
            while (nacc < 4 && rdy[nacc] && rd_valid_rob2rt[nacc]) nacc++;
            for (int r = 0; r < 32; r++) for (int b = 0; b < VLENB; b++) owner[r][b] = -1;
            for (int i = 0; i < nacc; i++)
                if (lane_vrf(i))
                    for (int b = 0; b < VLENB; b++)
                        if (rd_rob2rt[i].vd_type[b] == BODY_ACTIVE) owner[rd_rob2rt[i].w_index][b] = i;
            m_vv = '0;
            for (int i = 0; i < nacc; i++) begin
                if (lane_vrf(i)) begin
                    m_vrf[i].rt_index = rd_rob2rt[i].w_index;
                    m_vrf[i].rt_data  = rd_rob2rt[i].w_data;
                    for (int b = 0; b < VLENB; b++)
                        m_vrf[i].rt_strobe[b] = (owner[rd_rob2rt[i].w_index][b] == i);
                    m_vv[i] = |m_vrf[i].rt_strobe;
                end
            end
            m_vxsat = 0;
            for (int i = 0; i < nacc; i++) if (rd_rob2rt[i].vxsaturate != 0) m_vxsat = 1;
            if (m_xv && wr_ready_xrf2rt) m_xv = 0;
            for (int i = 0; i < nacc; i++) begin
                if (lane_xrf(i)) begin
                    m_xv = 1;
                    m_xdata.rt_data  = rd_rob2rt[i].w_data[XLEN-1:0];
                    m_xdata.rt_index = rd_rob2rt[i].w_index;
                end
            end
            if (m_trap) begin
                if (trap_done_ready) m_trap = 0;
            end else begin
                for (int i = 0; i < nacc; i++) if (rd_rob2rt[i].trap_flag) m_trap = 1;
            end
            m_run = 1;
        end
    end

    // Compare every cycle at the falling edge.
    always @(negedge clk) begin
        chk("ready", rd_ready_rt2rob, model_ready());
        chk("vrf_valid", wr_valid_rt2vrf, m_vv);
        for (int i = 0; i < 4; i++)
            if (m_vv[i]) chk($sformatf("vrf_lane%0d", i), wr_rt2vrf[i], m_vrf[i]);
        chk("xrf_valid", wr_valid_rt2xrf, m_xv);
        if (m_xv) chk("xrf_data", wr_rt2xrf, m_xdata);
        chk("vxsat", vxsat_valid, m_vxsat);
        chk("trap_done", trap_done_valid, m_trap);
    end

    // ---------------- stimulus ----------------
    function automatic ROB2RT_t mk(input bit wv, input int idx, input logic [127:0] data,
                                   input w_type_e t, input logic [15:0] act,
                                   input bit trap, input logic [15:0] vxs);
        ROB2RT_t r;
        r = '0;
        r.w_valid    = wv;
        r.w_index    = idx[4:0];
        r.w_data     = data;
        r.w_type     = t;
        for (int b = 0; b < VLENB; b++) r.vd_type[b] = act[b] ? BODY_ACTIVE : BODY_INACTIVE;
        r.trap_flag  = trap;
        r.vector_csr = 32'h0;
        r.vxsaturate = vxs;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rd_valid_rob2rt = '0;
        rd_rob2rt       = '0;
        wr_ready_xrf2rt = 1'b1;
        trap_done_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ready", rd_ready_rt2rob, 4'h0);
        chk("rst_vrf", wr_valid_rt2vrf, 4'h0);
        chk("rst_xrf", wr_valid_rt2xrf, 1'b0);
        chk("rst_trap", trap_done_valid, 1'b0);
        #19 rst_n = 1'b1;
        tick();

        // 1: four distinct full writes
        rd_rob2rt[0] = mk(1, 1, {4{32'hA1A1_0001}}, VRF, 16'hFFFF, 0, 0);
        rd_rob2rt[1] = mk(1, 2, {4{32'hB2B2_0002}}, VRF, 16'hFFFF, 0, 0);
        rd_rob2rt[2] = mk(1, 3, {4{32'hC3C3_0003}}, VRF, 16'hFFFF, 0, 0);
        rd_rob2rt[3] = mk(1, 4, {4{32'hD4D4_0004}}, VRF, 16'hFFFF, 0, 0);
        rd_valid_rob2rt = 4'hF;
        #1 chk("t1_ready", rd_ready_rt2rob, 4'hF);
        tick();
        rd_valid_rob2rt = '0; rd_rob2rt = '0;
        chk("t1_vrf_valid", wr_valid_rt2vrf, 4'hF);
        chk("t1_strobe3", wr_rt2vrf[3].rt_strobe, 16'hFFFF);
        chk("t1_data2", wr_rt2vrf[2].rt_data, {4{32'hC3C3_0003}});
        chk("t1_index0", wr_rt2vrf[0].rt_index, 5'd1);
        tick();

        // 2: WAW on v3 between lanes 0 and 2
        rd_rob2rt[0] = mk(1, 3, {4{32'h1111_1111}}, VRF, 16'hFFFF, 0, 0);
        rd_rob2rt[1] = mk(0, 0, '0, VRF, 16'h0000, 0, 0);
        rd_rob2rt[2] = mk(1, 3, {4{32'h2222_2222}}, VRF, 16'h00FF, 0, 0);
        rd_rob2rt[3] = mk(0, 0, '0, VRF, 16'h0000, 0, 0);
        rd_valid_rob2rt = 4'hF;
        tick();
        rd_valid_rob2rt = '0; rd_rob2rt = '0;
        chk("t2_vrf_valid", wr_valid_rt2vrf, 4'b0101);
        chk("t2_strobe0", wr_rt2vrf[0].rt_strobe, 16'hFF00);
        chk("t2_strobe2", wr_rt2vrf[2].rt_strobe, 16'h00FF);
        tick();

        // 3: two XRF uops with a stalled scalar port
        wr_ready_xrf2rt = 1'b0;
        rd_rob2rt[0] = mk(1, 5, 128'h1111_0005, XRF, 16'h0, 0, 0);
        rd_rob2rt[1] = mk(1, 6, 128'h2222_0006, XRF, 16'h0, 0, 0);
        rd_valid_rob2rt = 4'b0011;
        #1 chk("t3_ready", rd_ready_rt2rob, 4'b0001);
        tick();
        rd_rob2rt = '0;
        rd_rob2rt[0] = mk(1, 6, 128'h2222_0006, XRF, 16'h0, 0, 0);
        rd_valid_rob2rt = 4'b0001;
        #1 chk("t3_blocked", rd_ready_rt2rob, 4'b0000);
        chk("t3_xrf_hold", wr_rt2xrf, {32'h1111_0005, 5'd5});
        tick();
        tick();
        chk("t3_xrf_still", wr_valid_rt2xrf, 1'b1);
        wr_ready_xrf2rt = 1'b1;
        #1 chk("t3_drain_ready", rd_ready_rt2rob, 4'hF);
        tick();
        rd_valid_rob2rt = '0; rd_rob2rt = '0;
        chk("t3_xrf_second", wr_rt2xrf, {32'h2222_0006, 5'd6});
        tick();
        chk("t3_xrf_empty", wr_valid_rt2xrf, 1'b0);

        // 4: trap on lane 1
        rd_rob2rt[0] = mk(1, 7,  {4{32'h7777_7777}}, VRF, 16'hFFFF, 0, 0);
        rd_rob2rt[1] = mk(1, 8,  {4{32'h8888_8888}}, VRF, 16'hFFFF, 1, 0);
        rd_rob2rt[2] = mk(1, 9,  {4{32'h9999_9999}}, VRF, 16'hFFFF, 0, 0);
        rd_rob2rt[3] = mk(1, 10, {4{32'hAAAA_AAAA}}, VRF, 16'hFFFF, 0, 0);
        rd_valid_rob2rt = 4'hF;
        #1 chk("t4_ready", rd_ready_rt2rob, 4'b0011);
        tick();
        rd_valid_rob2rt = '0; rd_rob2rt = '0;
        chk("t4_vrf_valid", wr_valid_rt2vrf, 4'b0001);
        for (int k = 0; k < 3; k++) begin
            chk("t4_trap_valid", trap_done_valid, 1'b1);
            chk("t4_trap_ready", rd_ready_rt2rob, 4'h0);
            if (k < 2) tick();
        end
        trap_done_ready = 1'b1;
        tick();
        trap_done_ready = 1'b0;
        chk("t4_trap_clear", trap_done_valid, 1'b0);
        chk("t4_idle_ready", rd_ready_rt2rob, 4'hF);
        tick();

        // 5: vxsat from lane 2
        rd_rob2rt[2] = mk(0, 0, '0, VRF, 16'h0, 0, 16'h0004);
        rd_valid_rob2rt = 4'b0111;
        tick();
        rd_valid_rob2rt = '0; rd_rob2rt = '0;
        chk("t5_vxsat_on", vxsat_valid, 1'b1);
        tick();
        chk("t5_vxsat_off", vxsat_valid, 1'b0);

        // 6: reset while trapped with a full scalar buffer
        wr_ready_xrf2rt = 1'b0;
        rd_rob2rt[0] = mk(1, 3, 128'h3333_0003, XRF, 16'h0, 0, 0);
        rd_rob2rt[1] = mk(0, 0, '0, VRF, 16'h0, 1, 0);
        rd_valid_rob2rt = 4'b0011;
        #1 chk("t6_ready", rd_ready_rt2rob, 4'b0011);
        tick();
        rd_valid_rob2rt = '0; rd_rob2rt = '0;
        chk("t6_trapped", trap_done_valid, 1'b1);
        chk("t6_xrf_full", wr_valid_rt2xrf, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_xrf", wr_valid_rt2xrf, 1'b0);
        chk("t6_rst_trap", trap_done_valid, 1'b0);
        chk("t6_rst_ready", rd_ready_rt2rob, 4'h0);
        chk("t6_rst_vrf", wr_valid_rt2vrf, 4'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        chk("t6_ready0", rd_ready_rt2rob[0], 1'b1);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
